flash_reader: RTL and testbench
===============================

// Module: flash_reader
// PURPOSE
//  SPI (mode 0) reader for the on-board boot flash. Issues READ (0x03) + 24-bit address, then streams bytes MSB-first.
//  Sits between the flash pins and core's boot copy: core starts one transfer per boot and moves bytes into RAM via ramio.
//  Byte stream uses valid/ready. SPI clock pauses low while the consumer stalls.
// PARAMETERS
//  ClkHalfPeriodCycles  1   clk cycles per flash_clk phase (low or high); >=1
//  CsHighCycles         2   min clk cycles flash_cs_n held high after a transfer before next start accepted; >=1
//  ByteCountBitWidth    24  width of byte_count
// PORTS
//  clk         in   1   system clock (27 MHz)
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   one-cycle request; sampled only when busy=0
//  address     in   24  flash byte address; captured on accepted start
//  byte_count  in   ByteCountBitWidth  bytes to read; captured on accepted start
//  data_out    out  8   received byte; stable while data_valid=1
//  data_valid  out  1   data_out holds a byte not yet accepted
//  data_ready  in   1   consumer accepts; transfer when data_valid&data_ready
//  busy        out  1   high from cycle after accepted start until done pulse (inclusive of CS-high hold)
//  done        out  1   one-cycle pulse when transfer fully complete
//  flash_clk   out  1   SPI clock, idle low
//  flash_miso  in   1   SPI data from flash
//  flash_mosi  out  1   SPI data to flash
//  flash_cs_n  out  1   SPI chip select, active low
// BEHAVIOUR
//  Reset (async, immediate): flash_cs_n=1, flash_clk=0, flash_mosi=0, data_out=0, data_valid=0, busy=0, done=0, FSM=IDLE.
//  Reset mid-transfer aborts at once; no done pulse; captured address/count discarded.
//  FSM: IDLE -> SHIFT_OUT -> SHIFT_IN <-> WAIT_READY -> CS_HOLD -> IDLE.
//  - IDLE: start=1 with byte_count!=0 -> load 32-bit shift reg {0x03,address}, cs_n=0 next cycle, busy=1 -> SHIFT_OUT.
//    start with byte_count==0 -> no SPI activity; busy=1 one cycle, then done pulse, cs_n stays 1.
//    start while busy: ignored.
//  - Phases: each SPI bit = low phase (H cycles) then high phase (H cycles), H=ClkHalfPeriodCycles.
//    First low phase begins on the cycle cs_n falls. mosi valid from start of low phase (changes only while flash_clk=0).
//  - SHIFT_OUT: 32 bits, MSB first. mosi=0 after the last command bit -> SHIFT_IN.
//  - SHIFT_IN: miso sampled on the clk edge that ends each high phase (flash_clk 1->0), shifted in MSB first.
//    After 8th sample: data_out<=byte, data_valid<=1 on same edge, decrement remaining -> WAIT_READY.
//  - WAIT_READY: flash_clk held 0, cs_n held 0, data_out frozen.
//    On data_valid&data_ready: data_valid<=0. If remaining!=0, next low phase starts the following cycle (SHIFT_IN).
//    If remaining==0: cs_n<=1 -> CS_HOLD.
//    data_ready asserted in advance does not skip the valid cycle (data_valid high >=1 cycle per byte).
//  - CS_HOLD: cs_n=1 for CsHighCycles cycles; on the final cycle done=1 for one cycle; busy=0 the following cycle -> IDLE.
//  Per transfer: exactly 32+8*byte_count flash_clk rising edges; flash_clk never high while cs_n=1.
//  remaining counter ByteCountBitWidth bits; max count 2^W-1; address wrap beyond 0xFFFFFF is the flash's concern.
// TESTING
//  1. H=1, address=0x020000, count=4, ready=1, flash model bytes A5 3C FF 00
//     -> mosi stream 03 02 00 00; data_out sequence A5,3C,FF,00; 64 rising edges; one done pulse.
//  2. Backpressure: count=3, data_ready low 10 cycles on byte 2
//     -> data_out/data_valid stable, flash_clk low, cs_n low throughout stall; bytes intact, no extra edges.
//  3. count=0 -> cs_n never low, zero flash_clk edges, done pulses on cycle 2 after start, busy high only 1 cycle.
//  4. start pulsed again during transfer, and on cycle after done -> first ignored, second accepted; cs_n high >=CsHighCycles between.
//  5. Assert rst while in SHIFT_IN of byte 2
//     -> same cycle (async) cs_n=1, flash_clk=0, data_valid=0, busy=0; no done; new start afterwards reads correctly.
//  6. H=3, count=2 -> each flash_clk phase 3 cycles; mosi changes only while flash_clk=0; data correct.

Source files
------------

// File: rtl/flash_reader.sv
// -----------------------------------------------------------------------------
// flash_reader
//   SPI mode-0 reader for the boot flash. It sends a READ command (0x03) and a
//   24-bit address, then streams the requested number of bytes MSB-first to a
//   valid/ready consumer. While the consumer stalls, the SPI clock stays low.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   start       one-cycle transfer request, sampled only while busy=0
//   address     flash byte address, captured on an accepted start
//   byte_count  number of bytes to read, captured on an accepted start
//   data_out    received byte, stable while data_valid=1
//   data_valid  data_out holds a byte the consumer has not yet taken
//   data_ready  consumer accepts data_out when data_valid&data_ready
//   busy        high from the cycle after an accepted start through done
//   done        one-cycle pulse when the transfer has fully completed
//   flash_clk   SPI clock, idle low
//   flash_miso  SPI data from the flash
//   flash_mosi  SPI data to the flash
//   flash_cs_n  SPI chip select, active low
// -----------------------------------------------------------------------------
module flash_reader #(
   parameter int ClkHalfPeriodCycles = 1,
   parameter int CsHighCycles        = 2,
   parameter int ByteCountBitWidth   = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [23:0]                  address,
   input  logic [ByteCountBitWidth-1:0] byte_count,
   output logic [7:0]                   data_out,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic                         busy,
   output logic                         done,
   output logic                         flash_clk,
   input  logic                         flash_miso,
   output logic                         flash_mosi,
   output logic                         flash_cs_n
);

   localparam logic [7:0] ReadCmd = 8'h03;

   localparam int PhaseW = (ClkHalfPeriodCycles > 1) ? $clog2(ClkHalfPeriodCycles) : 1;
   localparam int HoldW  = (CsHighCycles > 1) ? $clog2(CsHighCycles) : 1;

   localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(ClkHalfPeriodCycles - 1);
   localparam logic [HoldW-1:0]  HoldLast  = HoldW'(CsHighCycles - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_OUT,
      SHIFT_IN,
      WAIT_READY,
      CS_HOLD
   } state_t;

   state_t                       state;
   logic [PhaseW-1:0]            phase_cnt;
   logic [4:0]                   bit_cnt;
   logic [31:0]                  shift_reg;
   logic [6:0]                   rx_reg;
   logic [ByteCountBitWidth-1:0] remaining;
   logic [HoldW-1:0]             hold_cnt;

   logic phase_end;
   assign phase_end = (phase_cnt == PhaseLast);

   // NOTE: every register here, outputs included, is assigned with <= so all
   // of them update together on the edge; the async reset clears them at once,
   // which is what aborts a transfer without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         rx_reg     <= '0;
         remaining  <= '0;
         hold_cnt   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         flash_clk  <= 1'b0;
         flash_mosi <= 1'b0;
         flash_cs_n <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (busy) begin
                  // Only a zero-length request leaves busy set in IDLE:
                  // finish it here without touching the SPI pins.
                  busy <= 1'b0;
                  done <= 1'b1;
               end else if (start) begin
                  busy <= 1'b1;
                  if (byte_count != '0) begin
                     shift_reg  <= {ReadCmd, address};
                     flash_mosi <= ReadCmd[7];
                     flash_cs_n <= 1'b0;
                     flash_clk  <= 1'b0;
                     remaining  <= byte_count;
                     phase_cnt  <= '0;
                     bit_cnt    <= '0;
                     state      <= SHIFT_OUT;
                  end
               end
            end

            SHIFT_OUT, SHIFT_IN: begin
               if (!phase_end) begin
                  phase_cnt <= phase_cnt + 1'b1;
               end else begin
                  phase_cnt <= '0;
                  if (!flash_clk) begin
                     flash_clk <= 1'b1;
                  end else begin
                     // End of the high phase: the falling edge is where mosi
                     // advances and miso is sampled.
                     flash_clk <= 1'b0;
                     bit_cnt   <= bit_cnt + 5'd1;
                     if (state == SHIFT_OUT) begin
                        shift_reg  <= {shift_reg[30:0], 1'b0};
                        flash_mosi <= shift_reg[30];
                        if (bit_cnt == 5'd31) begin
                           flash_mosi <= 1'b0;
                           bit_cnt    <= '0;
                           state      <= SHIFT_IN;
                        end
                     end else begin
                        rx_reg <= {rx_reg[5:0], flash_miso};
                        if (bit_cnt == 5'd7) begin
                           data_out   <= {rx_reg, flash_miso};
                           data_valid <= 1'b1;
                           remaining  <= remaining - 1'b1;
                           bit_cnt    <= '0;
                           state      <= WAIT_READY;
                        end
                     end
                  end
               end
            end

            WAIT_READY: begin
               // data_valid is always set here, so data_ready alone completes
               // the handshake; it can never land in the cycle valid rises.
               if (data_ready) begin
                  data_valid <= 1'b0;
                  if (remaining != '0) begin
                     phase_cnt <= '0;
                     state     <= SHIFT_IN;
                  end else begin
                     flash_cs_n <= 1'b1;
                     hold_cnt   <= '0;
                     done       <= (CsHighCycles == 1);
                     state      <= CS_HOLD;
                  end
               end
            end

            CS_HOLD: begin
               if (hold_cnt == HoldLast) begin
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                  done     <= (hold_cnt == HoldLast - 1'b1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_flash_reader
//   Two flash_reader instances (half period 1 and 3) with a behavioural SPI
//   flash on each. Expected bytes go into a queue when a transfer starts and
//   are compared against data_out whenever a handshake is about to happen.
// -----------------------------------------------------------------------------
module tb_flash_reader;

   localparam int CS_HIGH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  start_v = 2'b00;
   logic [23:0] address = '0;
   logic [23:0] byte_count = '0;
   logic        data_ready = 1'b1;

   wire  [7:0]  data_out_w [2];
   wire  [1:0]  dv_w, busy_w, done_w, fclk_w, mosi_w, csn_w;

   logic [7:0]  flash_mem [8];

   int tests_run = 0;
   int tests_failed = 0;
   logic [7:0] sb [$];

   int sel = 0;
   int exp_h = 1;

   // per-transfer observations gathered by run_xfer
   int          x_rises, x_stall, x_err, x_done, x_cs_tail;
   logic [31:0] x_cmd;

   always #5 clk = ~clk;

   initial begin
      flash_mem[0] = 8'hA5; flash_mem[1] = 8'h3C; flash_mem[2] = 8'hFF; flash_mem[3] = 8'h00;
      flash_mem[4] = 8'h12; flash_mem[5] = 8'h80; flash_mem[6] = 8'h7E; flash_mem[7] = 8'h01;
   end

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      logic miso = 1'b0;
      int   edges = 0;
      int   bidx = 0;

      flash_reader #(
         .ClkHalfPeriodCycles(g == 0 ? 1 : 3),
         .CsHighCycles       (CS_HIGH),
         .ByteCountBitWidth  (24)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_v[g]),
         .address   (address),
         .byte_count(byte_count),
         .data_out  (data_out_w[g]),
         .data_valid(dv_w[g]),
         .data_ready(data_ready),
         .busy      (busy_w[g]),
         .done      (done_w[g]),
         .flash_clk (fclk_w[g]),
         .flash_miso(miso),
         .flash_mosi(mosi_w[g]),
         .flash_cs_n(csn_w[g])
      );

      // Flash: after 32 command clocks, present the next data bit on each
      // falling edge so it is stable across the following rising edge.
      always @(posedge fclk_w[g] or negedge fclk_w[g] or posedge csn_w[g]) begin
         if (csn_w[g] !== 1'b0) begin
            edges = 0;
            bidx  = 0;
         end else if (fclk_w[g] === 1'b1) begin
            edges++;
         end else if (edges >= 32) begin
            miso = flash_mem[(bidx / 8) % 8][7 - (bidx % 8)];
            bidx++;
         end
      end
   end

   wire [7:0] do_m   = data_out_w[sel];
   wire       dv_m   = dv_w[sel];
   wire       busy_m = busy_w[sel];
   wire       done_m = done_w[sel];
   wire       fclk_m = fclk_w[sel];
   wire       mosi_m = mosi_w[sel];
   wire       csn_m  = csn_w[sel];

   // Call at a negedge with the DUT idle; returns at the negedge of the cycle
   // after the accepting edge.
   task automatic start_xfer(input logic [23:0] a, input logic [23:0] n);
      address = a;
      byte_count = n;
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
      for (int i = 0; i < int'(n); i++) sb.push_back(flash_mem[i % 8]);
      tests_run++;
      if (csn_m !== 1'b0 || busy_m !== 1'b1 || fclk_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_accept: cs_n=%b busy=%b flash_clk=%b, required 0 1 0", csn_m, busy_m, fclk_m);
      end
   endtask

   // Steps one cycle per negedge until done, driving data_ready and comparing
   // each handshaken byte against the scoreboard.
   task automatic run_xfer(input int budget, input int stall_at, input int stall_len, input int poke_at);
      int         byte_i, stall_cnt, high_run, low_run;
      logic       prev_fclk, prev_mosi, prev_dv, prev_rdy, got_done;
      logic [7:0] prev_do, exp;
      byte_i = 0; stall_cnt = 0; high_run = 0; low_run = 0;
      prev_fclk = 1'b0; prev_mosi = 1'b0; prev_dv = 1'b0; prev_rdy = 1'b1; prev_do = '0;
      got_done = 1'b0;
      x_rises = 0; x_stall = 0; x_err = 0; x_done = 0; x_cs_tail = 0; x_cmd = '0;
      for (int n = 0; n < budget; n++) begin
         if (prev_dv && !prev_rdy) begin
            x_stall++;
            if (dv_m !== 1'b1 || do_m !== prev_do || fclk_m !== 1'b0 || csn_m !== 1'b0) x_err++;
         end
         if (fclk_m && csn_m) x_err++;
         if (mosi_m !== prev_mosi && fclk_m !== 1'b0) x_err++;
         if (!prev_fclk && fclk_m) begin
            x_rises++;
            if (x_rises <= 32) x_cmd = {x_cmd[30:0], mosi_m};
            if (low_run < exp_h) x_err++;
            low_run = 0;
         end
         if (prev_fclk && !fclk_m) begin
            if (high_run != exp_h) x_err++;
            high_run = 0;
         end
         if (fclk_m) high_run++;
         else if (!csn_m) low_run++;
         if (csn_m) x_cs_tail++;
         else x_cs_tail = 0;

         if (dv_m && byte_i == stall_at && stall_cnt < stall_len) begin
            data_ready = 1'b0;
            stall_cnt++;
         end else begin
            data_ready = 1'b1;
         end
         if (dv_m && data_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL byte_unexpected: got %h, required no byte", do_m);
            end else begin
               exp = sb.pop_front();
               if (do_m !== exp) begin
                  tests_failed++;
                  $display("FAIL byte_%0d: got %h, required %h", byte_i, do_m, exp);
               end
            end
            byte_i++;
         end
         start_v[sel] = (n == poke_at);

         prev_fclk = fclk_m; prev_mosi = mosi_m; prev_dv = dv_m;
         prev_rdy = data_ready; prev_do = do_m;
         if (done_m) begin
            x_done++;
            got_done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      start_v[sel] = 1'b0;
      data_ready = 1'b1;
      if (!got_done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
   endtask

   task automatic check_xfer(input string name, input logic [31:0] cmd, input int rises);
      tests_run++;
      if (x_cmd !== cmd || x_rises != rises || x_err != 0 || sb.size() != 0) begin
         tests_failed++;
         $display("FAIL %s: cmd=%h rises=%0d proto_err=%0d left=%0d, required cmd=%h rises=%0d 0 0",
                  name, x_cmd, x_rises, x_err, sb.size(), cmd, rises);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         tests_run++;
         if ({csn_w[g], fclk_w[g], mosi_w[g], dv_w[g], busy_w[g], done_w[g], data_out_w[g]} !== {6'b100000, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_state_%0d: cs_n,clk,mosi,valid,busy,done,data=%b%b%b%b%b%b %h, required 100000 00",
                     g, csn_w[g], fclk_w[g], mosi_w[g], dv_w[g], busy_w[g], done_w[g], data_out_w[g]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      sel = 0; exp_h = 1;
      start_xfer(24'h020000, 24'd4);
      run_xfer(2000, -1, 0, -1);
      check_xfer("basic", 32'h03020000, 64);
      tests_run++;
      if (x_cs_tail != CS_HIGH) begin
         tests_failed++;
         $display("FAIL basic_cs_hold: cs_n high %0d cycles up to done, required %0d", x_cs_tail, CS_HIGH);
      end
      @(negedge clk);
      tests_run++;
      if (done_m !== 1'b0 || busy_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_after_done: done=%b busy=%b, required 0 0", done_m, busy_m);
      end
   endtask

   task automatic test_backpressure();
      sel = 0; exp_h = 1;
      start_xfer(24'h000100, 24'd3);
      run_xfer(2000, 1, 10, -1);
      check_xfer("backpressure", 32'h03000100, 56);
      tests_run++;
      if (x_stall != 10) begin
         tests_failed++;
         $display("FAIL backpressure_stall: stalled %0d cycles, required 10", x_stall);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_count();
      logic [2:0] got [3];
      logic [2:0] want [3];
      sel = 0;
      want[0] = 3'b100; want[1] = 3'b010; want[2] = 3'b000;
      address = 24'h0000FF;
      byte_count = '0;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         got[i] = {busy_m, done_m, fclk_m | ~csn_m};
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (got[i] !== want[i]) begin
            tests_failed++;
            $display("FAIL zero_count_cycle%0d: busy,done,spi=%b, required %b", i + 1, got[i], want[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      sel = 0; exp_h = 1;
      start_xfer(24'h123456, 24'd2);
      address = 24'hABCDEF;
      byte_count = 24'd5;
      run_xfer(2000, -1, 0, 20);
      check_xfer("b2b_first", 32'h03123456, 48);
      tests_run++;
      if (x_cs_tail != CS_HIGH) begin
         tests_failed++;
         $display("FAIL b2b_cs_hold: cs_n high %0d cycles up to done, required %0d", x_cs_tail, CS_HIGH);
      end
      @(negedge clk);
      tests_run++;
      if (busy_m !== 1'b0 || csn_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_gap: busy=%b cs_n=%b, required 0 1", busy_m, csn_m);
      end
      start_xfer(24'h000042, 24'd1);
      run_xfer(2000, -1, 0, -1);
      check_xfer("b2b_second", 32'h03000042, 40);
      @(negedge clk);
   endtask

   task automatic test_reset_midway();
      logic [7:0] exp;
      sel = 0; exp_h = 1;
      start_xfer(24'h000010, 24'd4);
      for (int i = 0; i < 200 && !dv_m; i++) @(negedge clk);
      tests_run++;
      if (!dv_m) begin
         tests_failed++;
         $display("FAIL midway_first_byte: data_valid=%b after wait, required 1", dv_m);
      end else begin
         exp = sb.pop_front();
         if (do_m !== exp) begin
            tests_failed++;
            $display("FAIL midway_first_byte: got %h, required %h", do_m, exp);
         end
      end
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (csn_m !== 1'b1 || fclk_m !== 1'b0 || dv_m !== 1'b0 || busy_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL midway_async_reset: cs_n=%b clk=%b valid=%b busy=%b, required 1 0 0 0",
                  csn_m, fclk_m, dv_m, busy_m);
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if (done_m !== 1'b0 || busy_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL midway_no_done: done=%b busy=%b, required 0 0", done_m, busy_m);
         end
      end
      start_xfer(24'h000020, 24'd2);
      run_xfer(2000, -1, 0, -1);
      check_xfer("midway_restart", 32'h03000020, 48);
      @(negedge clk);
   endtask

   task automatic test_slow_clock();
      sel = 1; exp_h = 3;
      start_xfer(24'h00ABCD, 24'd2);
      run_xfer(4000, -1, 0, -1);
      check_xfer("slow_clock", 32'h0300ABCD, 48);
      @(negedge clk);
      sel = 0; exp_h = 1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_count();
      test_back_to_back();
      test_reset_midway();
      test_slow_clock();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
